even_check_arb: RTL and testbench

//   Shares one div2 even/odd checker between two requesters.

---
 rtl/even_check_arb.sv | 171 +++++++++++++++++
 tb/tb_even_check_arb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/even_check_arb.sv
// even_check_arb: two requesters share one even/odd checker.
// A round-robin arbiter grants one requester per cycle into a single-entry
// result register. The registered word is classified by div2 and returned
// with the id of its requester. Saturating per-requester even/odd counters
// give status readback.
//
// state | meaning
// ------+-------------------------------------------------
// EMPTY | result register holds nothing, res_valid=0
// FULL  | result register holds a word, res_valid=1

module div2 #(
  parameter int IN_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0] data,
  output logic                ans
);

  logic unused_high_bits;

  // Only bit 0 decides parity; the rest of the word is intentionally ignored.
  assign unused_high_bits = ^data[IN_WIDTH-1:1];
  assign ans = ~data[0];

endmodule

module even_check_arb #(
  parameter int IN_WIDTH  = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [IN_WIDTH-1:0]  req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [IN_WIDTH-1:0]  req1_data,
  output logic                 req1_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IN_WIDTH-1:0]  res_data,
  output logic                 res_id,
  output logic                 res_even,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt_even0,
  output logic [CNT_WIDTH-1:0] cnt_odd0,
  output logic [CNT_WIDTH-1:0] cnt_even1,
  output logic [CNT_WIDTH-1:0] cnt_odd1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } occ_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  occ_t                 state_q, state_d;
  logic                 can_accept;
  logic                 last_grant_q;
  logic                 winner;
  logic                 accept0, accept1, accept_any;
  logic                 accept_id;
  logic [IN_WIDTH-1:0]  accept_data;
  logic [IN_WIDTH-1:0]  res_data_q;
  logic                 res_id_q;
  logic [CNT_WIDTH-1:0] cnt_even0_q, cnt_odd0_q, cnt_even1_q, cnt_odd1_q;

  // Occupancy state register; reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy: an accept always fills, a drain without accept empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept_any) state_d = FULL;
      FULL:  if (accept_any) state_d = FULL;
             else if (res_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy outputs: a new word may enter when empty or when the held one leaves.
  always_comb begin
    res_valid  = 1'b0;
    can_accept = 1'b0;
    case (state_q)
      EMPTY: begin
        res_valid  = 1'b0;
        can_accept = 1'b1;
      end
      FULL: begin
        res_valid  = 1'b1;
        can_accept = res_ready;
      end
      default: begin
        res_valid  = 1'b0;
        can_accept = 1'b0;
      end
    endcase
  end

  // Round-robin pick: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ~last_grant_q;
    else if (req1_valid)          winner = 1'b1;
    else                          winner = 1'b0;
  end

  // Ready is gated by valid so both stay low while nobody is asking.
  always_comb begin
    req0_ready  = can_accept && req0_valid && (winner == 1'b0);
    req1_ready  = can_accept && req1_valid && (winner == 1'b1);
    accept0     = req0_valid && req0_ready;
    accept1     = req1_valid && req1_ready;
    accept_any  = accept0 || accept1;
    accept_id   = accept1;
    accept_data = accept1 ? req1_data : req0_data;
  end

  // Result register and arbitration history; last_grant starts at 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept_any) begin
      res_data_q   <= accept_data;
      res_id_q     <= accept_id;
      last_grant_q <= accept_id;
    end
  end

  assign res_data = res_data_q;
  assign res_id   = res_id_q;

  div2 #(.IN_WIDTH(IN_WIDTH)) u_div2 (
    .data (res_data_q),
    .ans  (res_even)
  );

  // Saturating statistics; clr wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_even0_q <= '0;
      cnt_odd0_q  <= '0;
      cnt_even1_q <= '0;
      cnt_odd1_q  <= '0;
    end else if (clr) begin
      cnt_even0_q <= '0;
      cnt_odd0_q  <= '0;
      cnt_even1_q <= '0;
      cnt_odd1_q  <= '0;
    end else begin
      if (accept0 && !req0_data[0] && cnt_even0_q != CNT_MAX) cnt_even0_q <= cnt_even0_q + 1'b1;
      if (accept0 &&  req0_data[0] && cnt_odd0_q  != CNT_MAX) cnt_odd0_q  <= cnt_odd0_q + 1'b1;
      if (accept1 && !req1_data[0] && cnt_even1_q != CNT_MAX) cnt_even1_q <= cnt_even1_q + 1'b1;
      if (accept1 &&  req1_data[0] && cnt_odd1_q  != CNT_MAX) cnt_odd1_q  <= cnt_odd1_q + 1'b1;
    end
  end

  assign cnt_even0 = cnt_even0_q;
  assign cnt_odd0  = cnt_odd0_q;
  assign cnt_even1 = cnt_even1_q;
  assign cnt_odd1  = cnt_odd1_q;

endmodule

// File: tb/tb_even_check_arb.sv
// Bench for even_check_arb with a 2-bit counter width so saturation is reachable.
module tb_even_check_arb;

  localparam int IW = 16;
  localparam int CW = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [IW-1:0] req0_data, req1_data, res_data;
  logic          res_valid, res_ready, res_id, res_even, clr;
  logic [CW-1:0] cnt_even0, cnt_odd0, cnt_even1, cnt_odd1;

  even_check_arb #(.IN_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_even(res_even), .clr(clr),
    .cnt_even0(cnt_even0), .cnt_odd0(cnt_odd0),
    .cnt_even1(cnt_even1), .cnt_odd1(cnt_odd1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v0;
    logic [IW-1:0] d0;
    logic          v1;
    logic [IW-1:0] d1;
    logic          rr;
    logic          c;
    int            g;   // expected grant: 0 none, 1 requester 0, 2 requester 1
  } vec_t;

  typedef struct {
    logic [IW-1:0] data;
    logic          id;
    logic          even;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   m_even[2];
  int   m_odd[2];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v0, input int d0, input logic v1, input int d1,
                              input logic rr, input logic c, input int g);
    vec_t v;
    v.v0 = v0; v.d0 = d0[IW-1:0]; v.v1 = v1; v.d1 = d1[IW-1:0];
    v.rr = rr; v.c = c; v.g = g;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_even[i] = 0;
      m_odd[i]  = 0;
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, " cnt_even0"}, 32'(cnt_even0), 32'(m_even[0]));
    chk({tag, " cnt_odd0"},  32'(cnt_odd0),  32'(m_odd[0]));
    chk({tag, " cnt_even1"}, 32'(cnt_even1), 32'(m_even[1]));
    chk({tag, " cnt_odd1"},  32'(cnt_odd1),  32'(m_odd[1]));
  endtask

  task automatic step(input int idx, input vec_t v);
    logic [1:0]    exp_rdy;
    exp_t          e;
    logic [IW-1:0] wd;
    int            wid;
    string         tag;
    tag = $sformatf("v%0d", idx);
    req0_valid = v.v0; req0_data = v.d0;
    req1_valid = v.v1; req1_data = v.d1;
    res_ready  = v.rr; clr       = v.c;
    #1;
    exp_rdy = (v.g == 1) ? 2'b01 : (v.g == 2) ? 2'b10 : 2'b00;
    chk({tag, " readys"}, 32'({req1_ready, req0_ready}), 32'(exp_rdy));
    chk({tag, " res_valid"}, 32'(res_valid), 32'(exp_q.size() != 0));
    if (res_valid && exp_q.size() != 0) begin
      e = exp_q[0];
      chk({tag, " res_data"}, 32'(res_data), 32'(e.data));
      chk({tag, " res_id"},   32'(res_id),   32'(e.id));
      chk({tag, " res_even"}, 32'(res_even), 32'(e.even));
      if (res_ready) void'(exp_q.pop_front());
    end
    if (v.g != 0) begin
      wid = v.g - 1;
      wd  = (wid == 1) ? v.d1 : v.d0;
      e.data = wd; e.id = wid[0]; e.even = ~wd[0];
      exp_q.push_back(e);
    end
    if (v.c) model_clear();
    else if (v.g != 0) begin
      if (!wd[0]) m_even[wid] = (m_even[wid] < CMAX) ? m_even[wid] + 1 : CMAX;
      else        m_odd[wid]  = (m_odd[wid]  < CMAX) ? m_odd[wid]  + 1 : CMAX;
    end
    @(posedge clk);
    @(negedge clk);
    check_counters(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0;
    res_ready = 1'b0; clr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state, then reset asserted with a result in flight.
    #1;
    chk("rst readys", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    check_counters("rst");
    req0_valid = 1'b1; req0_data = 16'd5;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("pre-rst res_valid", 32'(res_valid), 32'd1);
    chk("pre-rst cnt_odd0", 32'(cnt_odd0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst res_valid", 32'(res_valid), 32'd0);
    chk("mid-rst res_data", 32'(res_data), 32'd0);
    chk("mid-rst cnt_odd0", 32'(cnt_odd0), 32'd0);
    chk("mid-rst readys", 32'({req1_ready, req0_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0 stream.
    vecs.push_back(mk(1, 65535, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 12348, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 64,    0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0, 1, 1, 0));
    // Zero word from requester 1.
    vecs.push_back(mk(0, 0,     1, 0, 1, 0, 2));
    // Contention, grants alternate starting with requester 0.
    vecs.push_back(mk(1, 15,    1, 6, 1, 0, 1));
    vecs.push_back(mk(1, 15,    1, 6, 1, 0, 2));
    vecs.push_back(mk(1, 15,    1, 6, 1, 0, 1));
    vecs.push_back(mk(1, 15,    1, 6, 1, 0, 2));
    vecs.push_back(mk(0, 0,     0, 0, 1, 0, 0));
    // Backpressure with 32 held for three cycles.
    vecs.push_back(mk(1, 32,    0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 2,     1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 2,     1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 2,     1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 2,     1, 3, 1, 0, 2));
    vecs.push_back(mk(1, 2,     1, 3, 1, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0, 1, 1, 0));
    // Saturation on requester 1 even counter.
    vecs.push_back(mk(0, 0,     1, 2,  1, 0, 2));
    vecs.push_back(mk(0, 0,     1, 4,  1, 0, 2));
    vecs.push_back(mk(0, 0,     1, 6,  1, 0, 2));
    vecs.push_back(mk(0, 0,     1, 8,  1, 0, 2));
    vecs.push_back(mk(0, 0,     1, 10, 1, 0, 2));
    vecs.push_back(mk(0, 0,     0, 0,  1, 0, 0));
    // clr coincident with an accept.
    vecs.push_back(mk(0, 0,     1, 12, 1, 1, 2));
    vecs.push_back(mk(0, 0,     0, 0,  1, 0, 0));
    // Empty register accepts even with res_ready low.
    vecs.push_back(mk(1, 7,     1, 9, 0, 0, 1));
    vecs.push_back(mk(1, 7,     1, 9, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    chk("sat cnt_even1 final", 32'(cnt_even1), 32'd0);
    chk("queue drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
